bsg_credit_rr_link_arbiter: RTL and testbench

- Shares one credit-flow-controlled output link among els_p ready/valid requesters.
- Holds the link's credit counter: +1 per returned credit, -1 per word sent.
- Picks the winning requester round-robin and steers its payload onto the link.
- Sits between several local producers and a single remote FIFO that returns credits, replacing one ready-to-credit converter per producer.

---
 rtl/bsg_credit_rr_link_arbiter.sv | 96 +++++++++
 tb/tb_bsg_credit_rr_link_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bsg_credit_rr_link_arbiter.sv
// Round-robin arbiter that shares one credit-flow-controlled link among els_p
// ready/valid requesters and tracks the remote buffer's credit count.
module bsg_credit_rr_link_arbiter #(
  parameter  int els_p            = 4,
  parameter  int width_p          = 32,
  parameter  int credit_max_val_p = 100,
  parameter  int credit_initial_p = 0,
  localparam int cnt_w            = $clog2(credit_max_val_p + 1),
  localparam int id_w             = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [id_w-1:0]            id_o,
  input  logic                       credit_i,
  output logic [cnt_w-1:0]           credit_cnt_o,
  output logic                       overflow_o
);

  localparam logic [cnt_w-1:0] cnt_max_lp = cnt_w'(credit_max_val_p);

  logic [cnt_w-1:0] credit_cnt_q, credit_cnt_d;
  logic [id_w-1:0]  rr_last_q, rr_last_d;
  logic [id_w-1:0]  grant_id, scan_id;
  logic             overflow_q, overflow_d;
  logic             found, have_credit;

  assign have_credit = (credit_cnt_q != '0);

  // Grant depends only on v_i and the pointer, so a credit-starved winner keeps priority.
  always_comb begin
    grant_id = '0;
    scan_id  = '0;
    found    = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      scan_id = id_w'((int'(rr_last_q) + 1 + k) % els_p);
      if (!found && v_i[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
  end

  assign v_o = reset_n_i & found & have_credit;

  always_comb begin
    ready_o = '0;
    if (v_o) ready_o[grant_id] = 1'b1;
  end

  // AND-OR steering keeps non-winning payloads off data_o entirely.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      if (v_o && (grant_id == id_w'(i))) data_o = data_i[i*width_p +: width_p];
    end
  end

  if (els_p == 1) begin : g_single
    assign id_o = '0;
  end else begin : g_multi
    assign id_o = v_o ? grant_id : '0;
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    overflow_d   = overflow_q;
    rr_last_d    = v_o ? grant_id : rr_last_q;
    if (v_o && !credit_i) begin
      credit_cnt_d = credit_cnt_q - cnt_w'(1);
    end else if (!v_o && credit_i) begin
      if (credit_cnt_q == cnt_max_lp) overflow_d = 1'b1;
      else                            credit_cnt_d = credit_cnt_q + cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      credit_cnt_q <= cnt_w'(credit_initial_p);
      rr_last_q    <= id_w'(els_p - 1);
      overflow_q   <= 1'b0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      rr_last_q    <= rr_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign credit_cnt_o = credit_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_bsg_credit_rr_link_arbiter.sv
// Directed bench for bsg_credit_rr_link_arbiter: a vector table for gating,
// round-robin, starvation priority and send/return, plus saturation and reset sequences.
module tb_bsg_credit_rr_link_arbiter;

  localparam int els_p = 4;
  localparam int width_p = 32;
  localparam int cnt_w = 7;
  localparam int id_w = 2;

  logic                     clk_i = 1'b0;
  logic                     reset_n_i;
  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         ready_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic [id_w-1:0]          id_o;
  logic                     credit_i;
  logic [cnt_w-1:0]         credit_cnt_o;
  logic                     overflow_o;

  bsg_credit_rr_link_arbiter #(
    .els_p(els_p), .width_p(width_p), .credit_max_val_p(100), .credit_initial_p(0)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .id_o(id_o),
    .credit_i(credit_i), .credit_cnt_o(credit_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_n;
    logic [3:0] v;
    logic       cr;
    logic       exp_vo;
    logic [3:0] exp_rdy;
    int         exp_id;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic rst_n, input logic [3:0] v, input logic cr,
                     input logic vo, input logic [3:0] rdy, input int id, input int cnt);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.cr = cr;
    r.exp_vo = vo; r.exp_rdy = rdy; r.exp_id = id; r.exp_cnt = cnt;
    vecs.push_back(r);
  endtask

  // Drive at the falling edge, sample 1ns later; the following rising edge commits.
  task automatic apply(input logic rst_n, input logic [3:0] v, input logic cr);
    @(negedge clk_i);
    reset_n_i = rst_n;
    v_i       = v;
    credit_i  = cr;
    #1;
  endtask

  task automatic check_link(input string tag, input logic vo, input logic [3:0] rdy, input int id);
    check({tag, " v_o"}, 64'(v_o), 64'(vo));
    check({tag, " ready_o"}, 64'(ready_o), 64'(rdy));
    if (vo) check({tag, " id_o"}, 64'(id_o), 64'(id));
    check({tag, " data_o"}, 64'(data_o), vo ? 64'(pat(id)) : 64'd0);
  endtask

  initial begin
    for (int i = 0; i < els_p; i++) data_i[i*width_p +: width_p] = pat(i);

    // Credit gating and single-credit drain.
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0001, 1, 0, 4'b0000, 0, 0);
    add(1, 4'b0001, 0, 1, 4'b0001, 0, 1);
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // Eight credits, then full round-robin sweep.
    for (int k = 0; k < 8; k++) add(1, 4'b0000, 1, 0, 4'b0000, 0, k);
    for (int k = 0; k < 8; k++) add(1, 4'b1111, 0, 1, 4'(1 << (k % 4)), k % 4, 8 - k);
    add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
    // Starved requester keeps priority.
    add(1, 4'b0110, 1, 0, 4'b0000, 0, 0);
    add(1, 4'b0110, 0, 1, 4'b0010, 1, 1);
    add(1, 4'b0110, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0110, 1, 0, 4'b0000, 0, 0);
    add(1, 4'b0110, 0, 1, 4'b0100, 2, 1);
    // Build count 5, then simultaneous send and return.
    for (int k = 0; k < 5; k++) add(1, 4'b0000, 1, 0, 4'b0000, 0, k);
    for (int k = 0; k < 10; k++) add(1, 4'b0001, 1, 1, 4'b0001, 0, 5);

    // Reset state, with requests and credits asserted to confirm gating.
    apply(0, 4'b1111, 1);
    check_link("rst0", 0, 4'b0000, 0);
    check("rst0 id_o", 64'(id_o), 64'd0);
    apply(0, 4'b1111, 1);
    check_link("rst1", 0, 4'b0000, 0);
    check("rst1 credit_cnt_o", 64'(credit_cnt_o), 64'd0);
    check("rst1 overflow_o", 64'(overflow_o), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].v, vecs[i].cr);
      check_link($sformatf("row%0d", i), vecs[i].exp_vo, vecs[i].exp_rdy, vecs[i].exp_id);
      check($sformatf("row%0d credit_cnt_o", i), 64'(credit_cnt_o), 64'(vecs[i].exp_cnt));
    end

    // Saturation and sticky overflow.
    apply(0, 4'b0000, 0);
    for (int k = 0; k < 100; k++) apply(1, 4'b0000, 1);
    apply(1, 4'b0000, 1);
    check("sat cnt at max", 64'(credit_cnt_o), 64'd100);
    check("sat no overflow yet", 64'(overflow_o), 64'd0);
    apply(1, 4'b0001, 1);
    check("sat overflow set", 64'(overflow_o), 64'd1);
    check("sat cnt held", 64'(credit_cnt_o), 64'd100);
    check_link("sat send", 1, 4'b0001, 0);
    apply(1, 4'b0000, 0);
    check("sat send+return cnt", 64'(credit_cnt_o), 64'd100);
    check("sat overflow sticky", 64'(overflow_o), 64'd1);
    apply(0, 4'b0000, 0);
    apply(1, 4'b0000, 0);
    check("sat reset overflow", 64'(overflow_o), 64'd0);
    check("sat reset cnt", 64'(credit_cnt_o), 64'd0);

    // Reset mid-operation at count 37 with the pointer moved off its reset value.
    for (int k = 0; k < 38; k++) apply(1, 4'b0000, 1);
    apply(1, 4'b1010, 0);
    check("mid pre cnt", 64'(credit_cnt_o), 64'd38);
    check_link("mid pre", 1, 4'b0010, 1);
    apply(0, 4'b1010, 0);
    check("mid rst cnt", 64'(credit_cnt_o), 64'd37);
    check_link("mid rst", 0, 4'b0000, 0);
    apply(1, 4'b1010, 1);
    check("mid post cnt", 64'(credit_cnt_o), 64'd0);
    check_link("mid post", 0, 4'b0000, 0);
    apply(1, 4'b1010, 0);
    check("mid grant cnt", 64'(credit_cnt_o), 64'd1);
    check_link("mid grant", 1, 4'b0010, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
